lc3_mmio_ctrl: RTL and testbench

Memory-mapped I/O device block on the LC-3 datapath's I/O port (addresses 0xFE00–0xFFFF).
- Holds KBSR/KBDR (keyboard, with receive FIFO), DSR/DDR (display) and MCR.
- Returns read data on the datapath's I/O input bus.
- Accepts store data and load strobe from the datapath.
- Drives the datapath's IRQ/INTP/INTV interrupt request inputs.

---
 rtl/lc3_mmio_pkg.sv | 28 ++
 rtl/lc3_kb_fifo.sv | 56 +++++
 rtl/lc3_mmio_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lc3_mmio_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mmio_pkg.sv
// Shared constants and types for the LC-3 memory-mapped I/O block.
package lc3_mmio_pkg;

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;
  localparam logic [15:0] MCR_A  = 16'hFFFE;

  localparam logic [7:0] KB_VEC  = 8'h80;
  localparam logic [7:0] DSP_VEC = 8'h81;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_KB,
    SRC_DSP
  } irq_src_e;

  // Vector delivered to the datapath for a given interrupt source.
  function automatic logic [7:0] src_vec(irq_src_e src);
    logic [7:0] vec;
    vec = 8'h00;
    if (src == SRC_KB) vec = KB_VEC;
    else if (src == SRC_DSP) vec = DSP_VEC;
    return vec;
  endfunction

endpackage

// File: rtl/lc3_kb_fifo.sv
// Small synchronous FIFO holding received keyboard characters.
// Push is refused when full and pop is refused when empty, so callers may
// present raw requests.
module lc3_kb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at the power-of-two depth; the count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 I/O page: keyboard (KBSR/KBDR with receive FIFO), display (DSR/DDR),
// machine control register and the interrupt request generator.
module lc3_mmio_ctrl
  import lc3_mmio_pkg::*;
#(
  parameter int         KB_DEPTH = 4,
  parameter logic [2:0] KB_PRIO  = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        io_load,
  input  logic        io_rd,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        irq,
  output logic [2:0]  intp,
  output logic [7:0]  intv,
  output logic        mcr_run
);

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       kb_push;
  logic       kb_pop;

  logic       kie_q;
  logic       die_q;
  logic       mcr_run_q;
  logic       dsp_valid_q;
  logic [7:0] dsp_data_q;
  logic       dsp_idle;

  logic       wr_kbsr;
  logic       wr_dsr;
  logic       wr_ddr;
  logic       wr_mcr;

  logic       kb_cond;
  logic       dsp_cond;
  logic       kb_prev_q;
  logic       dsp_prev_q;
  logic       kb_pend_q;
  logic       kb_pend_d;
  logic       dsp_pend_q;
  logic       dsp_pend_d;
  irq_src_e   issue_src;
  logic       irq_q;
  logic [2:0] intp_q;
  logic [7:0] intv_q;

  logic       unused_wdata;

  // Only the enable bits, the display byte and the run bit are ever stored.
  assign unused_wdata = ^wdata[13:8];

  // kb_ready reflects the occupancy before any same-cycle pop.
  assign kb_ready = ~fifo_full;
  assign kb_push  = kb_valid & kb_ready;
  assign kb_pop   = io_rd & (addr == KBDR_A) & ~fifo_empty;

  lc3_kb_fifo #(
    .DEPTH (KB_DEPTH),
    .WIDTH (8)
  ) u_kb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kb_push),
    .data_i  (kb_data),
    .pop_i   (kb_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_kbsr = io_load & (addr == KBSR_A);
  assign wr_dsr  = io_load & (addr == DSR_A);
  assign wr_ddr  = io_load & (addr == DDR_A);
  assign wr_mcr  = io_load & (addr == MCR_A);

  // The display is idle exactly when no character is waiting to be taken.
  assign dsp_idle  = ~dsp_valid_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;
  assign mcr_run   = mcr_run_q;
  assign irq       = irq_q;
  assign intp      = intp_q;
  assign intv      = intv_q;

  // Read mux for the I/O page; unmapped addresses read as zero.
  always_comb begin
    rdata = 16'h0000;
    case (addr)
      KBSR_A:  rdata = {~fifo_empty, kie_q, 14'b0};
      KBDR_A:  rdata = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
      DSR_A:   rdata = {dsp_idle, die_q, 14'b0};
      DDR_A:   rdata = {8'h00, dsp_data_q};
      MCR_A:   rdata = {mcr_run_q, 15'b0};
      default: rdata = 16'h0000;
    endcase
  end

  // Software-writable control bits: interrupt enables and machine-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kie_q     <= 1'b0;
      die_q     <= 1'b0;
      mcr_run_q <= 1'b1;
    end else begin
      if (wr_kbsr) kie_q     <= wdata[14];
      if (wr_dsr)  die_q     <= wdata[14];
      if (wr_mcr)  mcr_run_q <= wdata[15];
    end
  end

  // Display output register: a DDR store is only taken while idle and the
  // byte stays frozen until the consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 8'h00;
    end else if (wr_ddr && dsp_idle) begin
      dsp_valid_q <= 1'b1;
      dsp_data_q  <= wdata[7:0];
    end else if (dsp_valid_q && dsp_ready) begin
      dsp_valid_q <= 1'b0;
    end
  end

  // Pending flags latch a rising condition and drop once issued or once the
  // condition goes away; keyboard has precedence when both are waiting.
  always_comb begin
    kb_cond  = ~fifo_empty & kie_q;
    dsp_cond = dsp_idle & die_q;
    issue_src = SRC_NONE;
    if (kb_pend_q)       issue_src = SRC_KB;
    else if (dsp_pend_q) issue_src = SRC_DSP;
    kb_pend_d  = (kb_cond & ~kb_prev_q) |
                 (kb_pend_q & kb_cond & (issue_src != SRC_KB));
    dsp_pend_d = (dsp_cond & ~dsp_prev_q) |
                 (dsp_pend_q & dsp_cond & (issue_src != SRC_DSP));
  end

  // Edge history, pending flags and the registered one-cycle request pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_prev_q  <= 1'b0;
      dsp_prev_q <= 1'b0;
      kb_pend_q  <= 1'b0;
      dsp_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      intp_q     <= 3'd0;
      intv_q     <= 8'h00;
    end else begin
      kb_prev_q  <= kb_cond;
      dsp_prev_q <= dsp_cond;
      kb_pend_q  <= kb_pend_d;
      dsp_pend_q <= dsp_pend_d;
      irq_q      <= (issue_src != SRC_NONE);
      if (issue_src != SRC_NONE) begin
        intp_q <= KB_PRIO;
        intv_q <= src_vec(issue_src);
      end
    end
  end

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Directed self-checking bench for the LC-3 I/O page controller.
module tb_lc3_mmio_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        io_load;
  logic        io_rd;
  logic [15:0] rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready;
  logic        irq;
  logic [2:0]  intp;
  logic [7:0]  intv;
  logic        mcr_run;

  int testsRun;
  int testsFailed;

  lc3_mmio_ctrl #(
    .KB_DEPTH (4),
    .KB_PRIO  (3'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .io_load   (io_load),
    .io_rd     (io_rd),
    .rdata     (rdata),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready),
    .irq       (irq),
    .intp      (intp),
    .intv      (intv),
    .mcr_run   (mcr_run)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; io_load = 1'b1;
    tick();
    io_load = 1'b0;
  endtask

  task automatic kb_send(input logic [7:0] c);
    kb_valid = 1'b1; kb_data = c;
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic kb_pop();
    addr = 16'hFE02; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 16'h0000; wdata = 16'h0000; io_load = 1'b0; io_rd = 1'b0;
    kb_valid = 1'b0; kb_data = 8'h00; dsp_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    addr = 16'hFE04; #1;
    testsRun++; if (rdata !== 16'h8000) begin testsFailed++; $display("[TB] FAIL reset_dsr: got %h want 8000", rdata); end
    addr = 16'hFFFE; #1;
    testsRun++; if (rdata !== 16'h8000) begin testsFailed++; $display("[TB] FAIL reset_mcr: got %h want 8000", rdata); end
    addr = 16'hFE00; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_kbsr: got %h want 0000", rdata); end
    testsRun++; if (kb_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_kb_ready: got %b want 1", kb_ready); end
    testsRun++; if (irq !== 1'b0 || intp !== 3'd0 || intv !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_irq: got irq=%b intp=%0d intv=%h want 0/0/00", irq, intp, intv); end
    testsRun++; if (dsp_valid !== 1'b0 || dsp_data !== 8'h00 || mcr_run !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_outs: got dv=%b dd=%h run=%b want 0/00/1", dsp_valid, dsp_data, mcr_run); end
    addr = 16'hFE08; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL unmapped_read: got %h want 0000", rdata); end
  endtask

  task automatic test_keyboard();
    kb_send(8'h41);
    kb_send(8'h42);
    addr = 16'hFE00; #1;
    testsRun++; if (rdata !== 16'h8000) begin testsFailed++; $display("[TB] FAIL kb_kbsr_ready: got %h want 8000", rdata); end
    addr = 16'hFE02; #1;
    testsRun++; if (rdata !== 16'h0041) begin testsFailed++; $display("[TB] FAIL kb_head0: got %h want 0041", rdata); end
    kb_pop();
    #1;
    testsRun++; if (rdata !== 16'h0042) begin testsFailed++; $display("[TB] FAIL kb_head1: got %h want 0042", rdata); end
    kb_pop();
    addr = 16'hFE00; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL kb_kbsr_empty: got %h want 0000", rdata); end
    kb_pop();
    addr = 16'hFE02; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL kb_pop_empty: got %h want 0000", rdata); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] expected [4];
    expected[0] = 8'h32; expected[1] = 8'h33; expected[2] = 8'h34; expected[3] = 8'h35;
    for (int i = 0; i < 4; i++) kb_send(8'h31 + 8'(i));
    testsRun++; if (kb_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fifo_full_ready: got %b want 0", kb_ready); end
    kb_valid = 1'b1; kb_data = 8'h35; addr = 16'hFE02; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    tick();
    kb_valid = 1'b0;
    testsRun++; if (kb_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fifo_refill_ready: got %b want 0", kb_ready); end
    for (int i = 0; i < 4; i++) begin
      addr = 16'hFE02; #1;
      testsRun++; if (rdata !== {8'h00, expected[i]}) begin testsFailed++; $display("[TB] FAIL fifo_drain%0d: got %h want %h", i, rdata, {8'h00, expected[i]}); end
      kb_pop();
    end
    #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL fifo_drained: got %h want 0000", rdata); end
    testsRun++; if (kb_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL fifo_drained_ready: got %b want 1", kb_ready); end
  endtask

  task automatic test_display();
    io_write(16'hFE06, 16'h0058);
    testsRun++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin testsFailed++; $display("[TB] FAIL dsp_load: got dv=%b dd=%h want 1/58", dsp_valid, dsp_data); end
    addr = 16'hFE04; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL dsp_busy_dsr: got %h want 0000", rdata); end
    io_write(16'hFE06, 16'h0059);
    testsRun++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin testsFailed++; $display("[TB] FAIL dsp_drop: got dv=%b dd=%h want 1/58", dsp_valid, dsp_data); end
    tick();
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    testsRun++; if (dsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL dsp_accept_valid: got %b want 0", dsp_valid); end
    addr = 16'hFE04; #1;
    testsRun++; if (rdata !== 16'h8000) begin testsFailed++; $display("[TB] FAIL dsp_accept_dsr: got %h want 8000", rdata); end
    addr = 16'hFE06; #1;
    testsRun++; if (rdata !== 16'h0058) begin testsFailed++; $display("[TB] FAIL dsp_ddr_read: got %h want 0058", rdata); end
  endtask

  task automatic test_interrupts();
    io_write(16'hFE00, 16'h4000);
    io_write(16'hFE04, 16'h4000);
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_die_early: got %b want 0", irq); end
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h81 || intp !== 3'd4) begin testsFailed++; $display("[TB] FAIL irq_die_pulse: got irq=%b intv=%h intp=%0d want 1/81/4", irq, intv, intp); end
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_die_single: got %b want 0", irq); end

    kb_send(8'h30);
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_kb_early: got %b want 0", irq); end
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h80 || intp !== 3'd4) begin testsFailed++; $display("[TB] FAIL irq_kb_pulse: got irq=%b intv=%h intp=%0d want 1/80/4", irq, intv, intp); end
    tick();
    testsRun++; if (irq !== 1'b0 || intv !== 8'h80 || intp !== 3'd4) begin testsFailed++; $display("[TB] FAIL irq_kb_hold: got irq=%b intv=%h intp=%0d want 0/80/4", irq, intv, intp); end
    kb_pop();

    io_write(16'hFE06, 16'h0041);
    tick();
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_dsp_busy: got %b want 0", irq); end
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_dsp_early: got %b want 0", irq); end
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h81) begin testsFailed++; $display("[TB] FAIL irq_dsp_pulse: got irq=%b intv=%h want 1/81", irq, intv); end
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_dsp_single: got %b want 0", irq); end

    io_write(16'hFE06, 16'h0042);
    kb_valid = 1'b1; kb_data = 8'h31; dsp_ready = 1'b1;
    tick();
    kb_valid = 1'b0; dsp_ready = 1'b0;
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_both_early: got %b want 0", irq); end
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h80) begin testsFailed++; $display("[TB] FAIL irq_both_kb: got irq=%b intv=%h want 1/80", irq, intv); end
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h81) begin testsFailed++; $display("[TB] FAIL irq_both_dsp: got irq=%b intv=%h want 1/81", irq, intv); end
    tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_both_end: got %b want 0", irq); end

    io_write(16'hFE00, 16'h0000);
    io_write(16'hFE00, 16'h4000);
    addr = 16'hFE00; #1;
    testsRun++; if (rdata !== 16'hC000) begin testsFailed++; $display("[TB] FAIL kbsr_readback: got %h want c000", rdata); end
    tick();
    tick();
    testsRun++; if (irq !== 1'b1 || intv !== 8'h80) begin testsFailed++; $display("[TB] FAIL irq_kie_reenable: got irq=%b intv=%h want 1/80", irq, intv); end

    kb_pop();
    io_write(16'hFE00, 16'h0000);
    io_write(16'hFE04, 16'h0000);
    repeat (3) tick();
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_quiet: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    kb_send(8'h10);
    kb_valid = 1'b1; kb_data = 8'h11; addr = 16'hFE02; io_rd = 1'b1;
    tick();
    kb_valid = 1'b0; io_rd = 1'b0;
    #1;
    testsRun++; if (rdata !== 16'h0011) begin testsFailed++; $display("[TB] FAIL b2b_head: got %h want 0011", rdata); end
    kb_pop();
    addr = 16'hFE00; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL b2b_empty: got %h want 0000", rdata); end
  endtask

  task automatic test_mcr_reset();
    io_write(16'hFFFE, 16'h0000);
    testsRun++; if (mcr_run !== 1'b0) begin testsFailed++; $display("[TB] FAIL mcr_clear: got %b want 0", mcr_run); end
    addr = 16'hFFFE; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL mcr_read: got %h want 0000", rdata); end
    kb_send(8'h77);
    io_write(16'hFE06, 16'h0055);
    testsRun++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h55) begin testsFailed++; $display("[TB] FAIL mcr_dsp_load: got dv=%b dd=%h want 1/55", dsp_valid, dsp_data); end
    addr = 16'hFE00;
    #2;
    rst = 1'b1;
    #1;
    testsRun++; if (dsp_valid !== 1'b0 || mcr_run !== 1'b1) begin testsFailed++; $display("[TB] FAIL async_reset: got dv=%b run=%b want 0/1", dsp_valid, mcr_run); end
    testsRun++; if (rdata !== 16'h0000 || kb_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL async_reset_fifo: got kbsr=%h ready=%b want 0000/1", rdata, kb_ready); end
    tick();
    rst = 1'b0;
    tick();
    addr = 16'hFE02; #1;
    testsRun++; if (rdata !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_kbdr: got %h want 0000", rdata); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_keyboard();
    test_fifo_full();
    test_display();
    test_interrupts();
    test_back_to_back();
    test_mcr_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
